// File: rtl/core_mem_pkg.sv
// Shared types and constants for the two-port to single-port memory arbiter.
package core_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    WSIZE_BYTE  = 2'b00,
    WSIZE_HALF  = 2'b01,
    WSIZE_WORD  = 2'b10,
    WSIZE_WORDX = 2'b11
  } wsize_t;

  localparam logic PORT_DATA = 1'b0;
  localparam logic PORT_IF   = 1'b1;

endpackage

// File: rtl/mem_lane_align.sv
// Turns a write-size code and low address bits into byte enables and
// lane-replicated write data for a 32-bit little-endian bus.
module mem_lane_align
  import core_mem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lsb,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep
);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata;
    case (wsize_t'(size))
      WSIZE_BYTE: begin
        be        = 4'b0001 << addr_lsb;
        wdata_rep = {4{wdata[7:0]}};
      end
      WSIZE_HALF: begin
        be        = 4'b0011 << {addr_lsb[1], 1'b0};
        wdata_rep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// Serialises the core's data (port 0) and fetch (port 1) requests onto one
// memory bus. Define ARB_RR_EN for round-robin arbitration instead of fixed priority.
module core_mem_arbiter
  import core_mem_pkg::*;
#(
  parameter int BITSIZE = 32
) (
  input  logic                   clk,
  input  logic                   rst_i,
  input  logic [2*BITSIZE-1:0]   core_addr_i,
  input  logic [2*BITSIZE-1:0]   core_wdata_i,
  output logic [2*BITSIZE-1:0]   core_rdata_o,
  input  logic [1:0]             core_read_i,
  input  logic [1:0]             core_write_i,
  input  logic [3:0]             core_write_size_i,
  output logic [1:0]             core_valid_o,
  output logic [BITSIZE-1:0]     mem_addr_o,
  output logic [BITSIZE-1:0]     mem_wdata_o,
  output logic [3:0]             mem_be_o,
  output logic                   mem_req_o,
  output logic                   mem_we_o,
  input  logic [BITSIZE-1:0]     mem_rdata_i,
  input  logic                   mem_ready_i
);

  arb_state_t state;
  logic grant;
  logic pick;
  logic req0, req1, wr0;
  logic [BITSIZE-1:0] addr0, addr1, wdata0, wdata_aligned;
  logic [3:0] be_aligned;
  logic unused_inputs;

  assign addr0  = core_addr_i[BITSIZE-1:0];
  assign addr1  = core_addr_i[2*BITSIZE-1:BITSIZE];
  assign wdata0 = core_wdata_i[BITSIZE-1:0];
  assign wr0    = core_write_i[PORT_DATA];
  assign req0   = core_read_i[PORT_DATA] | wr0;
  assign req1   = core_read_i[PORT_IF];

  // Fetch port is read-only, so its write data, write bit and size are dead.
  assign unused_inputs = ^{core_wdata_i[2*BITSIZE-1:BITSIZE], core_write_i[PORT_IF],
                           core_write_size_i[3:2]};

  mem_lane_align u_lane_align (
    .size      (core_write_size_i[1:0]),
    .addr_lsb  (addr0[1:0]),
    .wdata     (wdata0),
    .be        (be_aligned),
    .wdata_rep (wdata_aligned)
  );

`ifdef ARB_RR_EN
  logic last_grant;

  always_comb begin
    if (req0 && req1) pick = ~last_grant;
    else              pick = ~req0;
  end

  always_ff @(posedge clk) begin
    if (rst_i)                           last_grant <= PORT_IF;
    else if (state == IDLE && (req0 || req1)) last_grant <= pick;
  end
`else
  assign pick = ~req0;
`endif

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state        <= IDLE;
      grant        <= PORT_DATA;
      core_rdata_o <= '0;
      core_valid_o <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      mem_be_o     <= '0;
      mem_req_o    <= 1'b0;
      mem_we_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          core_valid_o <= '0;
          if (req0 || req1) begin
            grant     <= pick;
            mem_req_o <= 1'b1;
            state     <= BUSY;
            if (pick == PORT_IF) begin
              mem_addr_o  <= addr1;
              mem_we_o    <= 1'b0;
              mem_be_o    <= 4'b0000;
              mem_wdata_o <= '0;
            end else begin
              mem_addr_o  <= addr0;
              mem_we_o    <= wr0;
              mem_be_o    <= wr0 ? be_aligned : 4'b0000;
              mem_wdata_o <= wr0 ? wdata_aligned : '0;
            end
          end
        end
        BUSY: begin
          if (mem_ready_i) begin
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_be_o     <= 4'b0000;
            core_valid_o <= (grant == PORT_IF) ? 2'b10 : 2'b01;
            state        <= DONE;
            if (!mem_we_o) begin
              if (grant == PORT_IF) core_rdata_o[2*BITSIZE-1:BITSIZE] <= mem_rdata_i;
              else                  core_rdata_o[BITSIZE-1:0]         <= mem_rdata_i;
            end
          end
        end
        DONE: begin
          core_valid_o <= '0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
